// File: rtl/vga_pkg.sv
// Shared constants, register map and bank type for the VGA frame registers.
// Imported by vga_vblank_strobe and vga_frame_regs.
package vga_pkg;

  localparam int HACTIVE_PX = 640;
  localparam int VACTIVE    = 480;

  localparam logic [2:0] ADDR_R      = 3'd0;
  localparam logic [2:0] ADDR_G      = 3'd1;
  localparam logic [2:0] ADDR_B      = 3'd2;
  localparam logic [2:0] ADDR_X      = 3'd3;
  localparam logic [2:0] ADDR_Y      = 3'd4;
  localparam logic [2:0] ADDR_COMMIT = 3'd5;
  localparam logic [2:0] ADDR_STATUS = 3'd6;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [9:0] x;
    logic [9:0] y;
  } frame_regs_t;

  localparam frame_regs_t REGS_RESET = '{
    r: 8'h80,
    g: 8'h00,
    b: 8'h80,
    x: 10'd500,
    y: 10'd200
  };

  function automatic logic [9:0] clamp(
    input logic [10:0] v,
    input logic [10:0] lim
  );
    logic [10:0] c;
    c = (v > lim) ? lim : v;
    return c[9:0];
  endfunction

endpackage

// File: rtl/vga_frame_regs_if.sv
// Avalon-MM slave bus bundle for the frame registers.
// master drives chipselect/write/read/address/writedata; slave returns readdata.
interface vga_frame_regs_if;

  logic        chipselect;
  logic        write;
  logic        read;
  logic [2:0]  address;
  logic [15:0] writedata;
  logic [15:0] readdata;

  modport master (
    output chipselect, write, read, address, writedata,
    input  readdata
  );

  modport slave (
    input  chipselect, write, read, address, writedata,
    output readdata
  );

endinterface

// File: rtl/vga_vblank_strobe.sv
// Detects the first clock of vertical blanking from the renderer counters.
// Ports: clk, reset, hcount, vcount in; strobe (comb), frame_pulse (reg) out.
module vga_vblank_strobe
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  output logic        strobe,
  output logic        frame_pulse
);

  // hcount advances every clk, so this is true for one clk per frame
  assign strobe = (hcount == 11'd0) &&
                  (vcount == 10'(VACTIVE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_pulse <= 1'b0;
    end else begin
      frame_pulse <= strobe;
    end
  end

endmodule

// File: rtl/vga_frame_regs.sv
// Double-buffered VGA registers: shadow bank commits to active at vblank.
// Ports: clk, reset, bus (Avalon slave), hcount/vcount in;
// color_r/g/b, x_cord, y_cord, frame_pulse, irq out.
// Optional: define VGA_FRAME_IRQ_EN for the commit interrupt.
module vga_frame_regs
  import vga_pkg::*;
#(
  parameter int FCNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  vga_frame_regs_if.slave  bus,
  input  logic [10:0]      hcount,
  input  logic [9:0]       vcount,
  output logic [7:0]       color_r,
  output logic [7:0]       color_g,
  output logic [7:0]       color_b,
  output logic [10:0]      x_cord,
  output logic [9:0]       y_cord,
  output logic             frame_pulse,
  output logic             irq
);

  frame_regs_t       shadow;
  frame_regs_t       active;
  logic              pending;
  logic [FCNT_W-1:0] frame_cnt;
  logic [15:0]       readdata;
  logic [15:0]       rdata;
  logic [15:0]       status;
  logic              strobe;
  logic              wr_en;
  logic              rd_en;
  logic              commit;
  logic              unused;

  assign unused = ^bus.writedata[15:11];

  vga_vblank_strobe u_strobe (
    .clk         (clk),
    .reset       (reset),
    .hcount      (hcount),
    .vcount      (vcount),
    .strobe      (strobe),
    .frame_pulse (frame_pulse)
  );

  assign wr_en  = bus.chipselect && bus.write;
  assign rd_en  = bus.chipselect && bus.read;
  assign commit = strobe && pending;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow <= REGS_RESET;
    end else if (wr_en) begin
      case (bus.address)
        ADDR_R: shadow.r <= bus.writedata[7:0];
        ADDR_G: shadow.g <= bus.writedata[7:0];
        ADDR_B: shadow.b <= bus.writedata[7:0];
        ADDR_X: shadow.x <= clamp(bus.writedata[10:0],
                                  11'(HACTIVE_PX - 1));
        ADDR_Y: shadow.y <= clamp({1'b0, bus.writedata[9:0]},
                                  11'(VACTIVE - 1));
        default: ;
      endcase
    end
  end

  // shadow here is the pre-edge value, so a same-edge write waits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active <= REGS_RESET;
    end else if (commit) begin
      active <= shadow;
    end
  end

  // a COMMIT on the strobe edge re-arms for the next frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= 1'b0;
    end else if (wr_en && bus.address == ADDR_COMMIT) begin
      pending <= 1'b1;
    end else if (strobe) begin
      pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (strobe) begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end

`ifdef VGA_FRAME_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else if (commit) begin
      irq_q <= 1'b1;
    end else if (rd_en && bus.address == ADDR_STATUS) begin
      irq_q <= 1'b0;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    status                = '0;
    status[15]            = pending;
    status[14]            = irq;
    status[FCNT_W-1:0]    = frame_cnt;
  end

  always_comb begin
    rdata = '0;
    case (bus.address)
      ADDR_R:      rdata = {8'h00, shadow.r};
      ADDR_G:      rdata = {8'h00, shadow.g};
      ADDR_B:      rdata = {8'h00, shadow.b};
      ADDR_X:      rdata = {6'b0, shadow.x};
      ADDR_Y:      rdata = {6'b0, shadow.y};
      ADDR_STATUS: rdata = status;
      default:     rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= '0;
    end else if (rd_en) begin
      readdata <= rdata;
    end
  end

  assign bus.readdata = readdata;

  assign color_r = active.r;
  assign color_g = active.g;
  assign color_b = active.b;
  assign x_cord  = {active.x, 1'b0};
  assign y_cord  = active.y;

endmodule

// File: tb/tb_vga_frame_regs.sv
// Scoreboard bench for vga_frame_regs: directed bus/strobe vectors.
// Build with or without VGA_FRAME_IRQ_EN.
module tb_vga_frame_regs;

`ifdef VGA_FRAME_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  typedef struct packed {
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic [10:0] x;
    logic [9:0]  y;
    logic        fp;
    logic        irq;
  } obs_t;

  logic        clk;
  logic        reset;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [7:0]  color_r;
  logic [7:0]  color_g;
  logic [7:0]  color_b;
  logic [10:0] x_cord;
  logic [9:0]  y_cord;
  logic        frame_pulse;
  logic        irq;
  logic        chk_req;

  vga_frame_regs_if bus ();

  vga_frame_regs dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .hcount      (hcount),
    .vcount      (vcount),
    .color_r     (color_r),
    .color_g     (color_g),
    .color_b     (color_b),
    .x_cord      (x_cord),
    .y_cord      (y_cord),
    .frame_pulse (frame_pulse),
    .irq         (irq)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [15:0] rd_q [$];
  obs_t        out_q [$];
  obs_t        cur;

  // read monitor: readdata is valid 1 clk after the read edge
  always @(posedge clk) begin
    if (bus.chipselect && bus.read) begin
      logic [2:0]  a;
      logic [15:0] e;
      a = bus.address;
      #1;
      n_chk++;
      if (rd_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_addr%0d: got %h, no expected value queued",
                 a, bus.readdata);
      end else begin
        e = rd_q.pop_front();
        if (bus.readdata !== e) begin
          n_fail++;
          $display("FAIL rd_addr%0d: got %h expected %h",
                   a, bus.readdata, e);
        end
      end
    end
  end

  // output monitor: samples the renderer-facing outputs on request
  always @(posedge chk_req) begin
    obs_t act;
    obs_t e;
    #1;
    act = '{r: color_r, g: color_g, b: color_b, x: x_cord,
            y: y_cord, fp: frame_pulse, irq: irq};
    n_chk++;
    if (out_q.size() == 0) begin
      n_fail++;
      $display("FAIL outputs: no expected value queued");
    end else begin
      e = out_q.pop_front();
      if (act !== e) begin
        n_fail++;
        $display("FAIL outputs: got r=%h g=%h b=%h x=%0d y=%0d fp=%b irq=%b expected r=%h g=%h b=%h x=%0d y=%0d fp=%b irq=%b",
                 act.r, act.g, act.b, act.x, act.y, act.fp, act.irq,
                 e.r, e.g, e.b, e.x, e.y, e.fp, e.irq);
      end
    end
  end

  function automatic logic [15:0] st(bit p, bit i, int c);
    return {p, i & IRQ, 6'b0, 8'(c)};
  endfunction

  // all stimulus tasks start and end just after a falling edge
  task automatic cyc(input bit wr, input bit rd, input logic [2:0] a,
                     input logic [15:0] d, input bit strb);
    bus.chipselect = wr | rd;
    bus.write      = wr;
    bus.read       = rd;
    bus.address    = a;
    bus.writedata  = d;
    if (strb) begin
      hcount = 11'd0;
      vcount = 10'd480;
    end
    @(posedge clk);
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
    bus.read       = 1'b0;
    hcount         = 11'd5;
    vcount         = 10'd100;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    cyc(1'b1, 1'b0, a, d, 1'b0);
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] e);
    rd_q.push_back(e);
    cyc(1'b0, 1'b1, a, 16'h0, 1'b0);
  endtask

  task automatic strobe();
    cyc(1'b0, 1'b0, 3'd0, 16'h0, 1'b1);
  endtask

  task automatic chk();
    out_q.push_back(cur);
    chk_req = 1'b1;
    #2;
    chk_req = 1'b0;
  endtask

  localparam obs_t RST = '{r: 8'h80, g: 8'h00, b: 8'h80, x: 11'd1000,
                           y: 10'd200, fp: 1'b0, irq: 1'b0};

  initial begin
    reset          = 1'b1;
    chk_req        = 1'b0;
    hcount         = 11'd5;
    vcount         = 10'd100;
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
    bus.read       = 1'b0;
    bus.address    = 3'd0;
    bus.writedata  = 16'h0;
    cur            = RST;

    @(negedge clk);
    chk();
    reset = 1'b0;
    @(negedge clk);
    rd(3'd6, st(0, 0, 0));
    rd(3'd7, 16'h0000);

    strobe();
    strobe();
    strobe();
    cur.fp = 1'b1;
    chk();
    rd(3'd6, st(0, 0, 3));
    cur.fp = 1'b0;

    wr(3'd3, 16'd100);
    wr(3'd4, 16'd50);
    strobe();
    strobe();
    cur.fp = 1'b1;
    chk();
    rd(3'd3, 16'd100);
    rd(3'd4, 16'd50);

    wr(3'd5, 16'h0);
    rd(3'd6, st(1, 0, 5));
    strobe();
    cur.x   = 11'd200;
    cur.y   = 10'd50;
    cur.irq = IRQ;
    cur.fp  = 1'b1;
    chk();
    rd(3'd6, st(0, 1, 6));
    cur.irq = 1'b0;
    cur.fp  = 1'b0;
    chk();

    wr(3'd3, 16'd900);
    wr(3'd4, 16'd700);
    wr(3'd5, 16'h0);
    strobe();
    cur.x   = 11'd1278;
    cur.y   = 10'd479;
    cur.irq = IRQ;
    cur.fp  = 1'b1;
    chk();
    rd(3'd3, 16'd639);
    rd(3'd4, 16'd479);
    rd(3'd6, st(0, 1, 7));
    cur.irq = 1'b0;
    cur.fp  = 1'b0;

    wr(3'd3, 16'd638);
    rd(3'd3, 16'd638);
    wr(3'd3, 16'd640);
    rd(3'd3, 16'd639);
    wr(3'd3, 16'd639);
    rd(3'd3, 16'd639);

    wr(3'd1, 16'h0010);
    wr(3'd5, 16'h0);
    cyc(1'b1, 1'b0, 3'd1, 16'h00FF, 1'b1);
    cur.g   = 8'h10;
    cur.irq = IRQ;
    cur.fp  = 1'b1;
    chk();
    rd(3'd1, 16'h00FF);
    rd(3'd6, st(0, 1, 8));
    cur.irq = 1'b0;
    strobe();
    chk();
    wr(3'd5, 16'h0);
    strobe();
    cur.g   = 8'hFF;
    cur.irq = IRQ;
    chk();
    rd(3'd6, st(0, 1, 10));
    cur.irq = 1'b0;

    wr(3'd0, 16'h0011);
    wr(3'd5, 16'h0);
    cyc(1'b1, 1'b0, 3'd5, 16'h0, 1'b1);
    cur.r   = 8'h11;
    cur.irq = IRQ;
    chk();
    rd(3'd6, st(1, 1, 11));
    cur.irq = 1'b0;
    strobe();
    cur.irq = IRQ;
    chk();
    rd(3'd6, st(0, 1, 12));
    cur.irq = 1'b0;

    wr(3'd7, 16'hFFFF);
    rd(3'd7, 16'h0000);

    wr(3'd2, 16'h0022);
    wr(3'd5, 16'h0);
    rd(3'd6, st(1, 0, 12));
    #5;
    reset = 1'b1;
    #1;
    cur = RST;
    chk();
    @(negedge clk);
    reset = 1'b0;
    strobe();
    cur.fp = 1'b1;
    chk();
    rd(3'd6, st(0, 0, 1));
    rd(3'd2, 16'h0080);

    repeat (3) @(negedge clk);
    n_chk++;
    if (rd_q.size() != 0 || out_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d reads and %0d output checks left, expected 0",
               rd_q.size(), out_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
